// File: rtl/sram_cache.sv
// 2-way set-associative, write-through, no-write-allocate data cache between the
// MEM stage and the SRAM controller; read hits answer combinationally in the request cycle.
module sram_cache #(
    parameter logic [31:0] DATA_BASE = 32'd1024,
    parameter int          SETS      = 64,
    parameter int          TAG_W     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_LO = IDX_W + 3;

    typedef enum logic [1:0] {IDLE, RMISS, WRITE} state_t;

    state_t                 state;
    logic [1:0][SETS-1:0]   valid;
    logic [SETS-1:0]        lru;
    logic [TAG_W-1:0]       tag_mem  [SETS][2];
    logic [31:0]            data_mem [SETS][2][2];

    logic [31:0]      ea;
    logic             word_sel;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit0;
    logic             hit1;
    logic             hit;
    logic             hit_way;
    logic             victim;
    logic [31:0]      hit_word;
    logic [31:0]      fill_word;
    logic             unused_ea;

    assign ea        = address - DATA_BASE;
    assign word_sel  = ea[2];
    assign idx       = ea[TAG_LO-1:3];
    assign tag       = ea[TAG_LO+TAG_W-1:TAG_LO];
    assign unused_ea = ^{ea[31:TAG_LO+TAG_W], ea[1:0]};

    // Way0 is checked first; fills only happen on a miss so both ways never hold the same tag.
    assign hit0      = valid[0][idx] && (tag_mem[idx][0] == tag);
    assign hit1      = !hit0 && valid[1][idx] && (tag_mem[idx][1] == tag);
    assign hit       = hit0 || hit1;
    assign hit_way   = hit1;
    assign hit_word  = data_mem[idx][hit_way][word_sel];
    assign victim    = !valid[0][idx] ? 1'b0 : (!valid[1][idx] ? 1'b1 : lru[idx]);
    assign fill_word = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];

    always_comb begin
        ready        = 1'b1;
        rdata        = '0;
        sram_address = address;
        sram_wdata   = wdata;
        case (state)
            IDLE: begin
                if (wr_en) begin
                    ready = 1'b0;
                end else if (rd_en) begin
                    if (hit) rdata = hit_word;
                    else     ready = 1'b0;
                end
            end
            RMISS: begin
                ready        = sram_ready;
                rdata        = fill_word;
                sram_address = {address[31:3], 3'b000};
            end
            WRITE: begin
                ready = sram_ready;
            end
            default: ready = 1'b1;
        endcase
        // A dropped request must not stall the pipeline while reset is held.
        if (!rst) begin
            ready = 1'b1;
            rdata = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sram_rd_en <= 1'b0;
            sram_wr_en <= 1'b0;
            valid      <= '0;
            lru        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        state      <= WRITE;
                        sram_wr_en <= 1'b1;
                    end else if (rd_en) begin
                        if (hit) begin
                            lru[idx] <= ~hit_way;
                        end else begin
                            state      <= RMISS;
                            sram_rd_en <= 1'b1;
                        end
                    end
                end
                RMISS: begin
                    if (sram_ready) begin
                        valid[victim][idx] <= 1'b1;
                        lru[idx]           <= ~victim;
                        state              <= IDLE;
                        sram_rd_en         <= 1'b0;
                    end
                end
                WRITE: begin
                    if (sram_ready) begin
                        if (hit) lru[idx] <= ~hit_way;
                        state      <= IDLE;
                        sram_wr_en <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    sram_rd_en <= 1'b0;
                    sram_wr_en <= 1'b0;
                end
            endcase
        end
    end

    // Tag and data storage carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (state == RMISS && sram_ready) begin
            tag_mem[idx][victim]     <= tag;
            data_mem[idx][victim][0] <= sram_rdata[31:0];
            data_mem[idx][victim][1] <= sram_rdata[63:32];
        end else if (state == WRITE && sram_ready && hit) begin
            data_mem[idx][hit_way][word_sel] <= wdata;
        end
    end

endmodule

// File: tb/tb_sram_cache.sv
// Bench for sram_cache: directed vector table, hand-written multi-cycle sequences, and
// random traffic checked against a recency-list cache model with its own shadow memory.
module tb_sram_cache;
    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   lat = 1;
    int   cnt;
    logic force_rdy = 1'b0;

    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    typedef struct {
        logic [9:0]  tag;
        logic [31:0] w0;
        logic [31:0] w1;
    } line_t;
    line_t cset[64][$];

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        int          l;
        logic [31:0] exp;
        int          low;
    } vec_t;
    vec_t tbl[12];

    sram_cache dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .wdata(wdata), .rdata(rdata), .ready(ready), .sram_rd_en(sram_rd_en),
        .sram_wr_en(sram_wr_en), .sram_address(sram_address), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dflt(input logic [31:0] k);
        return (k * 32'h0000_9E37) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        if (mem.exists(k)) return mem[k];
        return dflt(k);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        if (ref_mem.exists(k)) return ref_mem[k];
        return dflt(k);
    endfunction

    // SRAM controller: completes on the lat-th cycle its enable is seen high.
    assign sram_ready = force_rdy || ((sram_rd_en || sram_wr_en) && (cnt == lat - 1));

    always @(posedge clk or negedge rst) begin
        if (!rst)                          cnt <= 0;
        else if (sram_ready)               cnt <= 0;
        else if (sram_rd_en || sram_wr_en) cnt <= cnt + 1;
    end

    always @(negedge clk)
        sram_rdata <= {mem_rd({sram_address[31:3], 3'b100}), mem_rd({sram_address[31:3], 3'b000})};

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One request held until ready; reports data, stall cycles and bus behaviour.
    task automatic xact(input bit wr, input logic [31:0] a, input logic [31:0] d, input int l,
                        output logic [31:0] data, output int low,
                        output bit saw_rd, output bit saw_wr, output bit bus_ok);
        bit done;
        lat = l;
        @(posedge clk); #1;
        wr_en = wr; rd_en = !wr; address = a; wdata = d;
        low = 0; saw_rd = 0; saw_wr = 0; bus_ok = 1; data = '0; done = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk); #1;
            if (sram_rd_en) begin
                saw_rd = 1;
                if (sram_address !== {a[31:3], 3'b000}) bus_ok = 0;
            end
            if (sram_wr_en) begin
                saw_wr = 1;
                if (sram_address !== a || sram_wdata !== d) bus_ok = 0;
            end
            if (sram_rd_en && sram_wr_en) bus_ok = 0;
            if (ready) begin
                data = rdata;
                if (wr && sram_wr_en && sram_ready) mem[{sram_address[31:2], 2'b00}] = sram_wdata;
                done = 1;
                break;
            end
            low++;
        end
        if (!done) low = -1;
        @(posedge clk); #1;
        rd_en = 0; wr_en = 0;
    endtask

    task automatic run_op(input string nm, input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input int l, input logic [31:0] exp, input int exp_low);
        logic [31:0] got;
        int          low;
        bit          srd, swr, bok;
        xact(wr, a, d, l, got, low, srd, swr, bok);
        if (!wr) check({nm, "_rdata"}, got, exp);
        check({nm, "_stall"}, low, exp_low);
        check({nm, "_sram_rd"}, srd, (!wr && exp_low > 0));
        check({nm, "_sram_wr"}, swr, wr);
        check({nm, "_bus"}, bok, 1);
    endtask

    // Reference: each set is a recency list (front = least recent), at most two lines.
    function automatic void model_read(input logic [31:0] a, output logic [31:0] d, output bit hit);
        logic [31:0] ea;
        int          s;
        logic [9:0]  t;
        line_t       ln;
        ea = a - 32'd1024;
        s  = int'(ea[8:3]);
        t  = ea[18:9];
        for (int i = 0; i < cset[s].size(); i++) begin
            if (cset[s][i].tag == t) begin
                ln = cset[s][i];
                cset[s].delete(i);
                cset[s].push_back(ln);
                d   = ea[2] ? ln.w1 : ln.w0;
                hit = 1;
                return;
            end
        end
        ln.tag = t;
        ln.w0  = ref_rd({a[31:3], 3'b000});
        ln.w1  = ref_rd({a[31:3], 3'b100});
        if (cset[s].size() == 2) void'(cset[s].pop_front());
        cset[s].push_back(ln);
        d   = ea[2] ? ln.w1 : ln.w0;
        hit = 0;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] ea;
        int          s;
        line_t       ln;
        ea = a - 32'd1024;
        s  = int'(ea[8:3]);
        ref_mem[{a[31:2], 2'b00}] = d;
        for (int i = 0; i < cset[s].size(); i++) begin
            if (cset[s][i].tag == ea[18:9]) begin
                ln = cset[s][i];
                if (ea[2]) ln.w1 = d;
                else       ln.w0 = d;
                cset[s].delete(i);
                cset[s].push_back(ln);
                return;
            end
        end
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_d;
        logic [31:0] a;
        logic [31:0] d;
        bit          hit;
        bit          wr;
        bit          done;
        int          l;

        mem[32'd1024] = 32'hAAAA_AAAA;
        mem[32'd1028] = 32'hBBBB_BBBB;
        tbl[0]  = '{0, 32'd1024, 32'h0,      5, 32'hAAAA_AAAA,     5};
        tbl[1]  = '{0, 32'd1028, 32'h0,      5, 32'hBBBB_BBBB,     0};
        tbl[2]  = '{0, 32'd1536, 32'h0,      2, mem_rd(32'd1536),  2};
        tbl[3]  = '{0, 32'd2048, 32'h0,      2, mem_rd(32'd2048),  2};
        tbl[4]  = '{0, 32'd1536, 32'h0,      2, mem_rd(32'd1536),  0};
        tbl[5]  = '{0, 32'd1024, 32'h0,      2, 32'hAAAA_AAAA,     2};
        tbl[6]  = '{1, 32'd1024, 32'h1234,   3, 32'h0,             3};
        tbl[7]  = '{0, 32'd1024, 32'h0,      3, 32'h0000_1234,     0};
        tbl[8]  = '{1, 32'd4096, 32'hCAFE,   2, 32'h0,             2};
        tbl[9]  = '{0, 32'd4096, 32'h0,      2, 32'h0000_CAFE,     2};
        tbl[10] = '{0, 32'd8,    32'h0,      3, mem_rd(32'd8),     3};
        tbl[11] = '{0, 32'd15,   32'h0,      3, mem_rd(32'd12),    0};

        rst = 0; rd_en = 0; wr_en = 0; address = '0; wdata = '0;
        #1;
        check("reset_ready", ready, 1);
        check("reset_sram_rd", sram_rd_en, 0);
        check("reset_sram_wr", sram_wr_en, 0);
        check("reset_rdata", rdata, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1;

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].l,
                   tbl[i].exp, tbl[i].low);

        // Stray controller completion while idle must change nothing.
        @(posedge clk); #1 force_rdy = 1;
        @(negedge clk); #1;
        check("idle_rdy_ready", ready, 1);
        check("idle_rdy_rd", sram_rd_en, 0);
        @(posedge clk); #1 force_rdy = 0;
        @(negedge clk); #1;
        check("idle_rdy_after_rd", sram_rd_en, 0);
        check("idle_rdy_after_wr", sram_wr_en, 0);
        run_op("idle_rdy_hit", 0, 32'd1028, 32'h0, 2, 32'hBBBB_BBBB, 0);

        // Load withdrawn mid-miss: the fill still completes.
        lat = 4;
        @(posedge clk); #1 rd_en = 1; address = 32'd2560;
        repeat (2) @(negedge clk);
        #1 rd_en = 0;
        done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (!sram_rd_en) begin done = 1; break; end
        end
        check("drop_fill_done", done, 1);
        run_op("drop_fill_hit", 0, 32'd2564, 32'h0, 2, mem_rd(32'd2564), 0);

        // Reset asserted during a miss.
        lat = 10;
        @(posedge clk); #1 rd_en = 1; address = 32'd2048;
        repeat (3) @(negedge clk);
        #1;
        check("rmiss_sram_rd", sram_rd_en, 1);
        rst = 0;
        #1;
        check("rst_mid_sram_rd", sram_rd_en, 0);
        check("rst_mid_ready", ready, 1);
        check("rst_mid_rdata", rdata, 0);
        rd_en = 0;
        @(posedge clk); #1 rst = 1;

        for (int s = 0; s < 64; s++) cset[s].delete();
        ref_mem = mem;
        model_read(32'd1028, exp_d, hit);
        run_op("rst_reread", 0, 32'd1028, 32'h0, 3, exp_d, hit ? 0 : 3);

        for (int i = 0; i < 300; i++) begin
            wr = ($urandom_range(0, 3) == 0);
            a  = 32'd512 + 32'($urandom_range(0, 3)) * 32'd512 + 32'($urandom_range(0, 3)) * 32'd8
                 + 32'($urandom_range(0, 1)) * 32'd4 + 32'($urandom_range(0, 3));
            d  = $urandom;
            l  = $urandom_range(1, 4);
            if (wr) begin
                model_write(a, d);
                run_op($sformatf("rnd%0d_wr", i), 1, a, d, l, 32'h0, l);
            end else begin
                model_read(a, exp_d, hit);
                run_op($sformatf("rnd%0d_rd", i), 0, a, 32'h0, l, exp_d, hit ? 0 : l);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
